ddr_row_responder: RTL and testbench
====================================

// Module: ddr_row_responder
// PURPOSE
//  Memory-side responder for the word-burst read/write/acknowledge interface that the
//  Game of Life row engine uses to talk to the Ddr controller. It acts as a drop-in
//  responder backed by on-chip RAM, used for simulation and for builds without DDR.
//  It accepts 16-bit word writes and reads at 24-bit addresses, acknowledges one word
//  per handshake, and stalls acknowledges while servicing refresh requests.
// PARAMETERS
//  ADDR_BITS       15  low address bits used to index storage (depth = 2**ADDR_BITS words)
//  ACK_LATENCY     2   cycles from request seen in IDLE to acknowledge pulse (>=1)
//  REFRESH_CYCLES  8   cycles a refresh occupies; no acknowledges during this window (>=1)
// PORTS
//  clk               in   1   single clock; everything is on posedge
//  rst               in   1   asynchronous, active-low reset
//  read              in   1   level: initiator wants words at readAddress
//  readAddress       in   24  word address for the current read
//  readAcknowledge   out  1   one-cycle pulse: readData valid this cycle
//  readData          out  16  word at readAddress, valid when readAcknowledge=1
//  write             in   1   level: initiator presents writeData for writeAddress
//  writeAddress      in   24  word address for the current write
//  writeData         in   16  data for the current write
//  writeAcknowledge  out  1   one-cycle pulse: word stored this cycle
//  refresh           in   1   pulse: request one refresh window
//  busy              out  1   1 when state != IDLE
// BEHAVIOUR
//  - Reset (rst=0): readAcknowledge=0, writeAcknowledge=0, readData=0, busy=0,
//    refreshPending=0, state=IDLE, latency counter=0. RAM contents are not cleared.
//  - Storage: RAM indexed by address[ADDR_BITS-1:0]; upper address bits are ignored,
//    so addresses alias modulo 2**ADDR_BITS.
//  - States: IDLE, WAIT, ACK, GAP, REFRESH.
//  - IDLE: priority is refreshPending > write > read. Refresh -> REFRESH with
//    counter=REFRESH_CYCLES-1. Write or read -> WAIT with counter=ACK_LATENCY-1,
//    latching the operation type (write wins when write and read are both high).
//  - WAIT: decrement counter; at 0 go to ACK. If the latched request drops while
//    in WAIT, abandon it and return to IDLE with no acknowledge.
//  - ACK (exactly 1 cycle):
//    - write: store mem[writeAddress]=writeData and pulse writeAcknowledge.
//    - read: drive readData=mem[readAddress] and pulse readAcknowledge. The RAM read
//      is issued in the last WAIT cycle, so the address must be stable from WAIT to ACK.
//    - Then go to GAP.
//  - GAP (exactly 1 cycle): no acknowledge. This gives the initiator time to advance
//    its address/data or drop its request. Then return to IDLE.
//  - Sustained throughput: one word per ACK_LATENCY+2 cycles.
//  - refresh pulse in any state sets refreshPending. Multiple pulses before service
//    merge into one. Refresh is serviced only from IDLE, so it never splits an ACK.
//  - REFRESH: decrement counter; at 0 clear refreshPending and go to IDLE. A refresh
//    pulse arriving during REFRESH re-sets pending, giving one more window.
//  - readData holds its last value outside ACK cycles.
//  - busy = (state != IDLE), registered.
//  - Asserting reset mid-burst forces IDLE immediately. Any partial burst is lost,
//    but words already acknowledged stay in RAM.
// TESTING
//  1. Reset, then write=1 at addr 0x001000 with data 0xA5A5 -> writeAcknowledge high
//     for exactly 1 cycle, 3 cycles after request (ACK_LATENCY=2); busy deasserts
//     after GAP.
//  2. 40-word write burst at 0x001040 with data=index, then 40-word read burst from the
//     same base -> 40 readAcknowledge pulses returning 0..39 in order, spaced 4 cycles.
//  3. write and read both high in IDLE -> writeAcknowledge first; the read is served
//     only after write drops; no readAcknowledge during the write burst.
//  4. refresh pulse during an ACK -> that ACK completes, GAP, then 8 cycles with no acks;
//     two pulses before service -> one 8-cycle window only.
//  5. Address aliasing: write 0x1234 at 0x800005 -> read at 0x000005 returns 0x1234.
//  6. rst low during WAIT of a read -> no readAcknowledge, outputs 0; after release,
//     a new read returns correct data.

Source files
------------

// File: rtl/ddr_row_responder_if.sv
// Word-burst read/write/acknowledge bus between the row engine (master) and a memory responder (slave).
// Refresh request and busy status travel with the bus.
interface ddr_row_responder_if;
    logic        read;
    logic [23:0] readAddress;
    logic        readAcknowledge;
    logic [15:0] readData;
    logic        write;
    logic [23:0] writeAddress;
    logic [15:0] writeData;
    logic        writeAcknowledge;
    logic        refresh;
    logic        busy;

    modport master (
        output read, readAddress, write, writeAddress, writeData, refresh,
        input  readAcknowledge, readData, writeAcknowledge, busy
    );

    modport slave (
        input  read, readAddress, write, writeAddress, writeData, refresh,
        output readAcknowledge, readData, writeAcknowledge, busy
    );
endinterface

// File: rtl/ddr_row_responder.sv
// On-chip RAM responder for the row engine's DDR bus: one acknowledged word per handshake,
// with refresh windows inserted only between handshakes.
module ddr_row_responder #(
    parameter int ADDR_BITS      = 15,
    parameter int ACK_LATENCY    = 2,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    ddr_row_responder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT, ACK, GAP, REFRESH} state_t;

    localparam int          DEPTH        = 2 ** ADDR_BITS;
    localparam logic [15:0] ACK_LOAD     = 16'(ACK_LATENCY - 1);
    localparam logic [15:0] REFRESH_LOAD = 16'(REFRESH_CYCLES - 1);

    state_t         state, state_d;
    logic [15:0]    cnt, cnt_d;
    logic           op_write, op_write_d;
    logic           refresh_pending, refresh_pending_d;
    logic           mem_read, mem_write;
    logic [15:0]    mem [DEPTH];
    logic [15:0]    rd_word;
    logic [15:0]    read_data_q;
    logic           read_ack_q, write_ack_q, busy_q;
    logic [ADDR_BITS-1:0] rd_idx, wr_idx;
    logic           unused_high_addr;

    // Upper address bits alias onto the same RAM word.
    assign rd_idx           = bus.readAddress[ADDR_BITS-1:0];
    assign wr_idx           = bus.writeAddress[ADDR_BITS-1:0];
    assign unused_high_addr = ^{bus.readAddress[23:ADDR_BITS], bus.writeAddress[23:ADDR_BITS]};

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        op_write_d = op_write;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        unique case (state)
            IDLE: begin
                if (refresh_pending) begin
                    state_d = REFRESH;
                    cnt_d   = REFRESH_LOAD;
                end else if (bus.write) begin
                    state_d    = WAIT;
                    cnt_d      = ACK_LOAD;
                    op_write_d = 1'b1;
                end else if (bus.read) begin
                    state_d    = WAIT;
                    cnt_d      = ACK_LOAD;
                    op_write_d = 1'b0;
                end
            end
            WAIT: begin
                if (op_write ? !bus.write : !bus.read) begin
                    state_d = IDLE;
                end else if (cnt <= 16'd1) begin
                    // Last wait cycle: the RAM read is launched here so data is ready in ACK.
                    state_d  = ACK;
                    cnt_d    = '0;
                    mem_read = !op_write;
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            ACK: begin
                state_d   = GAP;
                mem_write = op_write;
            end
            GAP: state_d = IDLE;
            REFRESH: begin
                if (cnt == '0) state_d = IDLE;
                else           cnt_d   = cnt - 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending is consumed on entry to REFRESH, so a pulse during the window arms one more.
    always_comb begin
        refresh_pending_d = refresh_pending;
        if (bus.refresh)                              refresh_pending_d = 1'b1;
        else if (state == IDLE && state_d == REFRESH) refresh_pending_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            op_write        <= 1'b0;
            refresh_pending <= 1'b0;
            read_ack_q      <= 1'b0;
            write_ack_q     <= 1'b0;
            read_data_q     <= '0;
            busy_q          <= 1'b0;
        end else begin
            state           <= state_d;
            cnt             <= cnt_d;
            op_write        <= op_write_d;
            refresh_pending <= refresh_pending_d;
            read_ack_q      <= (state == ACK) && !op_write;
            write_ack_q     <= (state == ACK) && op_write;
            if (state == ACK && !op_write) read_data_q <= rd_word;
            busy_q          <= (state_d != IDLE);
        end
    end

    // NOTE: the RAM has no reset so it maps onto block RAM and keeps acknowledged words across rst.
    always_ff @(posedge clk) begin
        if (mem_write) mem[wr_idx] <= bus.writeData;
        if (mem_read)  rd_word     <= mem[rd_idx];
    end

    assign bus.readAcknowledge  = read_ack_q;
    assign bus.writeAcknowledge = write_ack_q;
    assign bus.readData         = read_data_q;
    assign bus.busy             = busy_q;
endmodule

// File: tb/tb_ddr_row_responder.sv
// Directed bench for ddr_row_responder: table of single-word ops plus hand-written burst,
// priority, refresh and reset sequences. Outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_ddr_row_responder;
    localparam int ACK_LATENCY    = 2;
    localparam int REFRESH_CYCLES = 8;
    localparam int FIRST_LAT      = ACK_LATENCY + 1;              // request driven -> ack sampled
    localparam int PERIOD         = ACK_LATENCY + 2;              // sustained word spacing
    localparam int WINDOW         = REFRESH_CYCLES + 1;           // refresh window plus its IDLE exit
    localparam int TIMEOUT        = 60;

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [11];

    ddr_row_responder_if bus ();

    ddr_row_responder #(
        .ADDR_BITS     (15),
        .ACK_LATENCY   (ACK_LATENCY),
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Wait for the wanted ack; cycles = negedges counted (-1 on timeout), other = opposite acks seen.
    task automatic wait_ack(input bit want_write, output int cycles, output int other);
        bit seen;
        cycles = 0;
        other  = 0;
        seen   = 1'b0;
        while (!seen && cycles < TIMEOUT) begin
            @(negedge clk);
            cycles++;
            seen = want_write ? bus.writeAcknowledge : bus.readAcknowledge;
            if (want_write ? bus.readAcknowledge : bus.writeAcknowledge) other++;
        end
        if (!seen) cycles = -1;
    endtask

    task automatic do_op(input logic wr, input logic [23:0] addr, input logic [15:0] data,
                         output logic [15:0] rdata, output int lat);
        int other;
        if (wr) begin
            bus.write        = 1'b1;
            bus.writeAddress = addr;
            bus.writeData    = data;
        end else begin
            bus.read        = 1'b1;
            bus.readAddress = addr;
        end
        wait_ack(wr, lat, other);
        rdata     = bus.readData;
        bus.write = 1'b0;
        bus.read  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, other;
        logic [15:0] rdata;

        vecs[0]  = '{1'b1, 24'h800005, 16'h1234, 16'h0000};
        vecs[1]  = '{1'b0, 24'h000005, 16'h0000, 16'h1234};
        vecs[2]  = '{1'b1, 24'h007FFF, 16'hBEEF, 16'h0000};
        vecs[3]  = '{1'b0, 24'hFF7FFF, 16'h0000, 16'hBEEF};
        vecs[4]  = '{1'b0, 24'h001000, 16'h0000, 16'hA5A5};
        vecs[5]  = '{1'b1, 24'h000000, 16'h0F0F, 16'h0000};
        vecs[6]  = '{1'b0, 24'h008000, 16'h0000, 16'h0F0F};
        vecs[7]  = '{1'b0, 24'h001045, 16'h0000, 16'h0005};
        vecs[8]  = '{1'b0, 24'h003001, 16'h0000, 16'h00E1};
        vecs[9]  = '{1'b0, 24'h003003, 16'h0000, 16'h00E3};
        vecs[10] = '{1'b0, 24'h002001, 16'h0000, 16'h3001};

        bus.read = 1'b0; bus.readAddress = '0;
        bus.write = 1'b0; bus.writeAddress = '0; bus.writeData = '0;
        bus.refresh = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset readAck", bus.readAcknowledge, 0);
        check("reset writeAck", bus.writeAcknowledge, 0);
        check("reset readData", bus.readData, 0);
        check("reset busy", bus.busy, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single write: ack exactly one cycle, FIRST_LAT after request; busy drops after GAP
        bus.write = 1'b1; bus.writeAddress = 24'h001000; bus.writeData = 16'hA5A5;
        @(negedge clk);
        check("t1 ack c1", bus.writeAcknowledge, 0);
        check("t1 busy c1", bus.busy, 1);
        @(negedge clk);
        check("t1 ack c2", bus.writeAcknowledge, 0);
        @(negedge clk);
        check("t1 ack c3", bus.writeAcknowledge, 1);
        check("t1 busy c3", bus.busy, 1);
        bus.write = 1'b0;
        @(negedge clk);
        check("t1 ack c4", bus.writeAcknowledge, 0);
        check("t1 busy c4", bus.busy, 0);

        // 40-word write burst then 40-word read burst
        bus.write = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.writeAddress = 24'h001040 + 24'(i);
            bus.writeData    = 16'(i);
            wait_ack(1'b1, lat, other);
            check($sformatf("t2 wr lat %0d", i), lat, (i == 0) ? FIRST_LAT : PERIOD);
        end
        bus.write = 1'b0;
        @(negedge clk);
        bus.read = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.readAddress = 24'h001040 + 24'(i);
            wait_ack(1'b0, lat, other);
            check($sformatf("t2 rd lat %0d", i), lat, (i == 0) ? FIRST_LAT : PERIOD);
            check($sformatf("t2 rd data %0d", i), bus.readData, i);
        end
        bus.read = 1'b0;
        @(negedge clk);

        // Write and read both high: writes win, read served after write drops
        bus.read = 1'b1; bus.readAddress = 24'h002002;
        bus.write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.writeAddress = 24'h002000 + 24'(i);
            bus.writeData    = 16'h3000 + 16'(i);
            wait_ack(1'b1, lat, other);
            check($sformatf("t3 wr lat %0d", i), lat, (i == 0) ? FIRST_LAT : PERIOD);
            check($sformatf("t3 no rdack %0d", i), other, 0);
        end
        bus.write = 1'b0;
        wait_ack(1'b0, lat, other);
        check("t3 rd lat", lat, PERIOD);
        check("t3 rd data", bus.readData, 16'h3002);
        bus.read = 1'b0;
        @(negedge clk);

        // Refresh pulses in ACK and GAP merge into a single window after the GAP
        bus.write = 1'b1; bus.writeAddress = 24'h003000; bus.writeData = 16'h00E0;
        @(negedge clk);
        @(negedge clk);
        bus.refresh = 1'b1;
        @(negedge clk);
        check("t4 ack completes", bus.writeAcknowledge, 1);
        bus.writeAddress = 24'h003001; bus.writeData = 16'h00E1;
        @(negedge clk);
        bus.refresh = 1'b0;
        check("t4 gap no ack", bus.writeAcknowledge, 0);
        wait_ack(1'b1, lat, other);
        check("t4 one window", lat, PERIOD + WINDOW - 1);
        bus.writeAddress = 24'h003002; bus.writeData = 16'h00E2;
        wait_ack(1'b1, lat, other);
        check("t4 no second window", lat, PERIOD);
        // Pulse in GAP, then another inside the window: two back-to-back windows
        bus.writeAddress = 24'h003003; bus.writeData = 16'h00E3;
        bus.refresh = 1'b1;
        @(negedge clk);
        bus.refresh = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t4 busy in refresh", bus.busy, 1);
        bus.refresh = 1'b1;
        @(negedge clk);
        bus.refresh = 1'b0;
        wait_ack(1'b1, lat, other);
        check("t4 rearmed window", lat, PERIOD + 2 * WINDOW - 4);
        bus.write = 1'b0;
        @(negedge clk);

        // Table of single-word ops, including address aliasing
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].wr, vecs[i].addr, vecs[i].data, rdata, lat);
            check($sformatf("vec %0d lat", i), lat, FIRST_LAT);
            if (!vecs[i].wr) check($sformatf("vec %0d data", i), rdata, vecs[i].exp);
            check($sformatf("vec %0d ack pulse", i),
                  vecs[i].wr ? bus.writeAcknowledge : bus.readAcknowledge, 0);
        end

        // Reset during WAIT of a read: no ack, outputs cleared, RAM kept
        bus.read = 1'b1; bus.readAddress = 24'h001000;
        @(negedge clk);
        check("t6 busy before rst", bus.busy, 1);
        rst = 1'b0;
        #1;
        check("t6 rst readData", bus.readData, 0);
        check("t6 rst busy", bus.busy, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t6 rst no ack %0d", i), bus.readAcknowledge, 0);
        end
        bus.read = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t6 after rst no ack", bus.readAcknowledge, 0);
        do_op(1'b0, 24'h001000, 16'h0000, rdata, lat);
        check("t6 read lat", lat, FIRST_LAT);
        check("t6 read data", rdata, 16'hA5A5);
        do_op(1'b0, 24'h001067, 16'h0000, rdata, lat);
        check("t6 burst word kept", rdata, 16'd39);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
